// File: rtl/serial_negate_ctrl_if.sv
// Handshake and data bundle between a parallel requester and
// serial_negate_ctrl: start/A_par in; busy/done/B_par/overflow/ser_a/ser_b out.
interface serial_negate_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A_par;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] B_par;
  logic             overflow;
  logic             ser_a;
  logic             ser_b;

  modport master (
    output start,
    output A_par,
    input  busy,
    input  done,
    input  B_par,
    input  overflow,
    input  ser_a,
    input  ser_b
  );

  modport slave (
    input  start,
    input  A_par,
    output busy,
    output done,
    output B_par,
    output overflow,
    output ser_a,
    output ser_b
  );
endinterface

// File: rtl/serial_negate_ctrl.sv
// Bit-serial two's-complement negator sequencer: IDLE/SHIFT/DONE.
// Ports: clock, reset_L (async low), bus (slave: start/A_par in, results out).
module serial_negate_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_L,
  serial_negate_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-2:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_b;
  logic             r_ovf;

  logic             w_shift;
  logic             w_last;
  logic             w_sum;
  logic [WIDTH-1:0] w_full;

  assign w_shift = (r_state == SHIFT);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));
  // ~A + 1, one bit per cycle; carry seeded to 1 on bit 0
  assign w_sum   = ~r_shreg[0] ^ r_carry;
  // current bit lands in the MSB of the partial result
  assign w_full  = {w_sum, r_res};

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = SHIFT;
      SHIFT:   if (w_last)    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_shreg <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_b     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shreg <= bus.A_par;
            r_cnt   <= '0;
            r_carry <= 1'b1;
          end
        end
        SHIFT: begin
          r_res   <= w_full[WIDTH-1:1];
          r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
          r_cnt   <= r_cnt + 1'b1;
          r_carry <= ~r_shreg[0] & r_carry;
          if (w_last) begin
            r_b   <= w_full;
            // only -2^(W-1) has both A and -A negative
            r_ovf <= r_shreg[0] & w_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = w_shift;
  assign bus.done     = (r_state == DONE);
  assign bus.B_par    = r_b;
  assign bus.overflow = r_ovf;
  assign bus.ser_a    = w_shift & r_shreg[0];
  assign bus.ser_b    = w_shift & w_sum;

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Self-checking bench for serial_negate_ctrl (WIDTH=8 and WIDTH=4).
// Table vectors, random ops against an arithmetic model, corner sequences.
module tb_serial_negate_ctrl;

  logic clock;
  logic reset_L;
  int   errors = 0;
  int   checks = 0;

  serial_negate_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_negate_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_negate_ctrl #(.WIDTH(8)) dut8 (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus8)
  );

  serial_negate_ctrl #(.WIDTH(4)) dut4 (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ovf;
    string      nm;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [7:0] neg8(input logic [7:0] a);
    int v;
    v = (256 - int'(a)) % 256;
    return 8'(v);
  endfunction

  function automatic logic ovf8(input logic [7:0] a);
    return (a == 8'h80);
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] eb,
                        input logic eo, input string nm,
                        input bit disturb);
    logic [7:0] prev_b;
    int         nbusy;
    bit         got;
    bit         bstable;
    bit         serok;
    int         ndone;
    prev_b  = bus8.B_par;
    nbusy   = 0;
    got     = 0;
    bstable = 1;
    serok   = 1;
    bus8.A_par = a;
    bus8.start = 1'b1;
    tick;
    bus8.start = 1'b0;
    for (int c = 0; c < 14 && !got; c++) begin
      if (bus8.done) begin
        got = 1;
      end else begin
        if (bus8.busy) begin
          if (nbusy < 8) begin
            if (bus8.ser_a !== a[nbusy] || bus8.ser_b !== eb[nbusy])
              serok = 0;
          end
          nbusy++;
        end
        if (bus8.B_par !== prev_b) bstable = 0;
        if (disturb && c == 2) begin
          bus8.A_par = ~a;
          bus8.start = 1'b1;
        end
        if (disturb && c == 3) bus8.start = 1'b0;
        tick;
      end
    end
    chk({nm, " done_seen"}, 32'(got), 32'd1);
    chk({nm, " busy_cycles"}, 32'(nbusy), 32'd8);
    chk({nm, " B_par"}, 32'(bus8.B_par), 32'(eb));
    chk({nm, " overflow"}, 32'(bus8.overflow), 32'(eo));
    chk({nm, " serial_bits"}, 32'(serok), 32'd1);
    chk({nm, " B_stable"}, 32'(bstable), 32'd1);
    tick;
    chk({nm, " done_pulse"}, 32'(bus8.done), 32'd0);
    chk({nm, " idle_busy"}, 32'(bus8.busy), 32'd0);
    if (disturb) begin
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
        if (bus8.done) ndone++;
        tick;
      end
      chk({nm, " no_extra_done"}, 32'(ndone), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] cur;
    int         dt[$];
    int         ndone;
    int         nbusy;
    bit         got;

    tbl[0] = '{8'h45, 8'hBB, 1'b0, "v45"};
    tbl[1] = '{8'h00, 8'h00, 1'b0, "v00"};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, "vFF"};
    tbl[3] = '{8'h01, 8'hFF, 1'b0, "v01"};
    tbl[4] = '{8'h80, 8'h80, 1'b1, "v80"};
    tbl[5] = '{8'h7F, 8'h81, 1'b0, "v7F"};

    reset_L    = 1'b0;
    bus8.start = 1'b0;
    bus8.A_par = '0;
    bus4.start = 1'b0;
    bus4.A_par = '0;
    tick;
    tick;
    chk("rst busy", 32'(bus8.busy), 32'd0);
    chk("rst done", 32'(bus8.done), 32'd0);
    chk("rst B_par", 32'(bus8.B_par), 32'd0);
    chk("rst overflow", 32'(bus8.overflow), 32'd0);
    chk("rst ser_a", 32'(bus8.ser_a), 32'd0);
    chk("rst ser_b", 32'(bus8.ser_b), 32'd0);
    reset_L = 1'b1;
    tick;

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].ovf, tbl[i].nm, 0);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      run_op(ra, neg8(ra), ovf8(ra), "rand", 0);
    end

    run_op(8'h3A, neg8(8'h3A), 1'b0, "disturb", 1);

    // reset after four bits of an op
    bus8.A_par = 8'h3C;
    bus8.start = 1'b1;
    tick;
    bus8.start = 1'b0;
    for (int c = 0; c < 4; c++) tick;
    chk("midop busy", 32'(bus8.busy), 32'd1);
    reset_L = 1'b0;
    #1;
    chk("abort busy", 32'(bus8.busy), 32'd0);
    chk("abort done", 32'(bus8.done), 32'd0);
    chk("abort B_par", 32'(bus8.B_par), 32'd0);
    chk("abort overflow", 32'(bus8.overflow), 32'd0);
    chk("abort ser_a", 32'(bus8.ser_a), 32'd0);
    chk("abort ser_b", 32'(bus8.ser_b), 32'd0);
    tick;
    reset_L = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus8.done) ndone++;
      tick;
    end
    chk("abort no_done", 32'(ndone), 32'd0);
    run_op(8'h01, 8'hFF, 1'b0, "post_reset", 0);

    // start held high: back-to-back ops
    cur = 8'h45;
    bus8.A_par = cur;
    bus8.start = 1'b1;
    tick;
    for (int t = 1; t <= 45; t++) begin
      if (bus8.done) begin
        dt.push_back(t);
        chk("b2b B_par", 32'(bus8.B_par), 32'(neg8(cur)));
        chk("b2b overflow", 32'(bus8.overflow), 32'(ovf8(cur)));
        cur = 8'($urandom);
        bus8.A_par = cur;
      end
      tick;
    end
    bus8.start = 1'b0;
    chk("b2b done_count", 32'(dt.size()), 32'd4);
    for (int i = 1; i < dt.size(); i++)
      chk("b2b spacing", 32'(dt[i] - dt[i-1]), 32'd10);
    for (int c = 0; c < 12; c++) tick;

    // WIDTH=4 instance
    bus4.A_par = 4'h5;
    bus4.start = 1'b1;
    tick;
    bus4.start = 1'b0;
    nbusy = 0;
    got   = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      if (bus4.done) got = 1;
      else begin
        if (bus4.busy) nbusy++;
        tick;
      end
    end
    chk("w4 done_seen", 32'(got), 32'd1);
    chk("w4 busy_cycles", 32'(nbusy), 32'd4);
    chk("w4 B_par", 32'(bus4.B_par), 32'hB);
    chk("w4 overflow", 32'(bus4.overflow), 32'd0);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
